fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 32, meaning the instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pc, output, 32 bits: byte address presented to the instruction memory.
REQ-006 SHALL have port instr, input, 32 bits: memory word at pc, valid combinationally in the same cycle.
REQ-007 SHALL have port fetch_en, input, 1 bit: 1 permits new fetches; 0 freezes fetching, but the queue still drains.
REQ-008 SHALL have port redirect, input, 1 bit: branch/jump taken this cycle.
REQ-009 SHALL have port redirect_pc, input, 32 bits: new fetch address when redirect=1.
REQ-010 SHALL have port out_valid, output, 1 bit: the queue head holds an instruction.
REQ-011 SHALL have port out_ready, input, 1 bit: the decode stage accepts the head this cycle.
REQ-012 SHALL have port out_instr, output, 32 bits: instruction at the queue head.
REQ-013 SHALL have port out_pc, output, 32 bits: address of the queue head instruction.
REQ-014 SHALL have port oob_err, output, 1 bit: sticky flag set on a fetch beyond the memory.

Function
REQ-015 SHALL keep a 2-entry FIFO of {pc, instr} pairs with an occupancy count of 0..2.
REQ-016 SHALL define pop as out_valid && out_ready.
REQ-017 SHALL define push as fetch_en && !redirect && !oob_err && (count<2 || pop).
REQ-018 On push, SHALL enqueue {pc, instr} and load pc <= pc+4 in the same edge; fetch latency is one cycle from pc to queue.
REQ-019 On pop, SHALL remove the head; on simultaneous push and pop, count SHALL be unchanged and order SHALL be preserved.
REQ-020 out_valid SHALL equal (count!=0).
REQ-021 out_instr and out_pc SHALL show the head entry, or 32'h0 when count==0.
REQ-022 When redirect=1, SHALL flush the FIFO (count <= 0) and load pc <= {redirect_pc[31:2], 2'b00}, with no push that edge.
REQ-023 When redirect=1, a pop in the same cycle SHALL still complete, and redirect SHALL override it for count.
REQ-024 pc SHALL be held when there is no push and no redirect.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 pc[1:0] SHALL always be 2'b00.
REQ-027 A fetch with (pc>>2) >= IMEM_WORDS SHALL not push and SHALL set oob_err.
REQ-028 oob_err SHALL stay set until reset or redirect; redirect clears it.
REQ-029 fetch_en=0 SHALL block push only; pop and redirect SHALL still act.

Reset
REQ-030 While rst_n=0, independent of clk: pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, oob_err=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries immediately.
REQ-032 The first push SHALL occur on the first rising edge after rst_n rises, if fetch_en=1.

Verification
REQ-033 Streaming: memory word k = 32'hA000_0000+k, fetch_en=1, out_ready=1 -> out_pc 0,4,8,... consecutively from cycle 2, out_instr matching, with no bubbles.
REQ-034 Backpressure: out_ready=0 for 5 cycles -> count saturates at 2, pc holds at 8, out_pc stays 0; releasing out_ready -> entries 0,4,8 are delivered in order.
REQ-035 Redirect with a full queue: redirect=1, redirect_pc=32'h0000_0043 -> next cycle out_valid=0, pc=32'h40; following cycle out_pc=32'h40.
REQ-036 Out of bounds: IMEM_WORDS=32, redirect to 32'h7C -> entry 0x7C is delivered, then oob_err=1, pc holds at 32'h80, no further pushes; redirect to 0 -> oob_err=0.
REQ-037 Asynchronous reset: drop rst_n between edges with count=2 -> out_valid=0 and pc=RESET_PC before the next edge.
REQ-038 Wrap: IMEM_WORDS=2^30, redirect_pc=32'hFFFF_FFFC -> the next pc is 32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives pc and buffers {pc, instr} pairs in a 2-entry queue; fetch latency is one cycle from pc to queue head.
// Backpressure: the queue fills while out_ready is low, then fetching stalls with pc held; a redirect flushes the queue and clears oob_err.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        oob_err
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [32:0] LP_WORDS = 33'(IMEM_WORDS);

    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic        r_oob;
    entry_t      r_q [0:1];

    logic   w_pop;
    logic   w_room;
    logic   w_try;
    logic   w_in_range;
    logic   w_push;
    logic   w_oob_hit;
    entry_t w_new;

    assign w_pop      = (r_count != 2'd0) && out_ready;
    assign w_room     = (r_count != 2'd2) || w_pop;
    assign w_try      = fetch_en && !redirect && !r_oob && w_room;
    // Word index compared in 33 bits so IMEM_WORDS up to 2^30 (the full space) works.
    assign w_in_range = ({3'b000, r_pc[31:2]} < LP_WORDS);
    assign w_push     = w_try && w_in_range;
    assign w_oob_hit  = w_try && !w_in_range;
    assign w_new      = '{pc: r_pc, instr: instr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= {RESET_PC[31:2], 2'b00};
            r_count <= 2'd0;
            r_oob   <= 1'b0;
            r_q[0]  <= '0;
            r_q[1]  <= '0;
        end else if (redirect) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_count <= 2'd0;
            r_oob   <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_oob_hit) begin
                r_oob <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_q[0] <= w_new;
                    end else begin
                        r_q[1] <= w_new;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q[0]  <= r_q[1];
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Head leaves and tail enters on the same edge; count is unchanged.
                    if (r_count == 2'd1) begin
                        r_q[0] <= w_new;
                    end else begin
                        r_q[0] <= r_q[1];
                        r_q[1] <= w_new;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign oob_err   = r_oob;
    assign out_valid = (r_count != 2'd0);
    assign out_pc    = out_valid ? r_q[0].pc    : 32'h0;
    assign out_instr = out_valid ? r_q[0].instr : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, instr;
    logic        fetch_en, redirect, out_ready;
    logic [31:0] redirect_pc;
    logic        out_valid, oob_err;
    logic [31:0] out_instr, out_pc;

    logic [31:0] w_pc, w_instr, w_out_instr, w_out_pc;
    logic        w_out_valid, w_oob_err;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_oob;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] < 30'd32) return 32'hA000_0000 + {2'b00, a[31:2]};
        return 32'hDEAD_BEEF;
    endfunction

    assign instr   = mem_word(pc);
    assign w_instr = 32'h1234_0000 ^ w_pc;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
        .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .oob_err(oob_err)
    );

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1 << 30)) dut_w (
        .clk(clk), .rst_n(rst_n), .pc(w_pc), .instr(w_instr),
        .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
        .out_pc(w_out_pc), .oob_err(w_oob_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc  = 32'h0;
        m_oob = 1'b0;
    endtask

    task automatic check_model();
        chk("out_valid", {31'b0, out_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
        chk("out_pc",    out_pc,    (m_q.size() != 0) ? m_q[0].pc  : 32'h0);
        chk("out_instr", out_instr, (m_q.size() != 0) ? m_q[0].ins : 32'h0);
        chk("pc",        pc,        m_pc);
        chk("oob_err",   {31'b0, oob_err}, {31'b0, m_oob});
    endtask

    // One clock cycle of the reference: pop from the front, flush on redirect, else fetch if room.
    task automatic model_step();
        int  n0;
        bit  pop;
        n0  = m_q.size();
        pop = (n0 != 0) && out_ready;
        if (pop) void'(m_q.pop_front());
        if (redirect) begin
            m_q.delete();
            m_pc  = {redirect_pc[31:2], 2'b00};
            m_oob = 1'b0;
        end else if (fetch_en && !m_oob && (n0 < 2 || pop)) begin
            if ((m_pc / 4) < 32) begin
                m_q.push_back('{pc: m_pc, ins: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end else begin
                m_oob = 1'b1;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, compare outputs, advance model, wait one cycle.
    task automatic cyc(input logic fe, input logic rd, input logic [31:0] rpc, input logic rdy);
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        check_model();
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        model_reset();
        #3;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_oob", {31'b0, oob_err}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with no bubbles
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("stream_head_pc", out_pc, 32'd44);
        chk("stream_head_ins", out_instr, 32'hA000_000B);

        // Backpressure from an empty queue at pc 0
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("bp_pc_hold", pc, 32'h8);
        chk("bp_out_pc", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect with a full queue
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0000_0043, 1'b1);
        chk("rd_valid", {31'b0, out_valid}, 32'd0);
        chk("rd_pc", pc, 32'h40);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rd_out_pc", out_pc, 32'h40);

        // Out of bounds at the last word
        cyc(1'b1, 1'b1, 32'h7C, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("oob_set", {31'b0, oob_err}, 32'd1);
        chk("oob_pc", pc, 32'h80);
        cyc(1'b1, 1'b1, 32'h0, 1'b1);
        chk("oob_clear", {31'b0, oob_err}, 32'd0);

        // Wrap on the full-space instance
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_pre", w_pc, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_pc", w_pc, 32'h0);

        // Asynchronous reset with a full queue
        cyc(1'b1, 1'b1, 32'h10, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("pre_arst_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 40) * 4) | {30'b0, 2'($urandom)};
            cyc(($urandom_range(0, 9) < 8), ($urandom_range(0, 15) == 0), rpc,
                ($urandom_range(0, 9) < 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
